// File: rtl/bwt_block_sched.sv
// bwt_block_sched: buffers one STRING_LEN-byte block from a valid/ready stream,
// replays it into bwt_top as a contiguous start-qualified burst, captures the
// transformed bytes returned on bwt_valid_out and drains them downstream.
// The next input block is accepted while the current one is in flight.
module bwt_block_sched #(
    parameter int STRING_LEN = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        bwt_start,
    output logic [7:0]  bwt_char,
    input  logic [7:0]  bwt_char_out,
    input  logic        bwt_valid_out,
    input  logic        clr_err,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_spurious,
    output logic [15:0] blocks_done
);

    localparam int CNT_W = $clog2(STRING_LEN + 1);
    localparam int IDX_W = $clog2(STRING_LEN);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(STRING_LEN);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(STRING_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST_C = TO_W'(TIMEOUT - 1);

    logic [1:0]       state_r,  state_nx;
    logic [CNT_W-1:0] in_cnt_r, in_cnt_nx;
    logic [CNT_W-1:0] ld_cnt_r, ld_cnt_nx;
    logic [CNT_W-1:0] oc_r,     oc_nx;
    logic [CNT_W-1:0] rd_r,     rd_nx;
    logic [TO_W-1:0]  wc_r,     wc_nx;

    logic [7:0] ibuf_r [STRING_LEN];
    logic [7:0] obuf_r [STRING_LEN];

    logic        in_acc_s;
    logic        cap_s;
    logic        to_s;
    logic        done_s;
    logic        spur_s;

    logic        in_ready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic        out_last_r;
    logic        bwt_start_r;
    logic [7:0]  bwt_char_r;
    logic        busy_r;
    logic        err_timeout_r;
    logic        err_spurious_r;
    logic [15:0] blocks_done_r;

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_last     = out_last_r;
    assign bwt_start    = bwt_start_r;
    assign bwt_char     = bwt_char_r;
    assign busy         = busy_r;
    assign err_timeout  = err_timeout_r;
    assign err_spurious = err_spurious_r;
    assign blocks_done  = blocks_done_r;

    // Next-state for the scheduler FSM, fill/drain counters and event strobes
    always_comb begin
        state_nx  = state_r;
        ld_cnt_nx = ld_cnt_r;
        oc_nx     = oc_r;
        rd_nx     = rd_r;
        wc_nx     = wc_r;
        cap_s     = 1'b0;
        to_s      = 1'b0;
        done_s    = 1'b0;
        in_acc_s  = in_valid && in_ready_r;
        if (in_acc_s) begin
            in_cnt_nx = in_cnt_r + 1'b1;
        end else begin
            in_cnt_nx = in_cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (in_cnt_r == LEN_C) begin
                    state_nx  = ST_LOAD;
                    ld_cnt_nx = '0;
                end else begin
                    state_nx  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_cnt_r == LAST_C) begin
                    state_nx  = ST_WAIT;
                    in_cnt_nx = '0;
                    wc_nx     = '0;
                end else begin
                    ld_cnt_nx = ld_cnt_r + 1'b1;
                end
            end
            ST_WAIT: begin
                // Timeout takes priority: a byte arriving on the same cycle is dropped.
                if (wc_r == TO_LAST_C) begin
                    to_s     = 1'b1;
                    oc_nx    = '0;
                    wc_nx    = '0;
                    state_nx = ST_IDLE;
                end else begin
                    wc_nx = wc_r + 1'b1;
                    if (bwt_valid_out) begin
                        cap_s = 1'b1;
                        oc_nx = oc_r + 1'b1;
                        if (oc_r == LAST_C) begin
                            state_nx = ST_DRAIN;
                            wc_nx    = '0;
                            rd_nx    = '0;
                        end else begin
                            state_nx = ST_WAIT;
                        end
                    end else begin
                        cap_s = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready) begin
                    if (rd_r == LAST_C) begin
                        rd_nx    = '0;
                        oc_nx    = '0;
                        done_s   = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        rd_nx = rd_r + 1'b1;
                    end
                end else begin
                    rd_nx = rd_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        spur_s = bwt_valid_out && (state_r != ST_WAIT);
    end

    // Block storage: input bytes by arrival index, results by capture index
    always_ff @(posedge clk) begin
        if (in_acc_s) begin
            ibuf_r[in_cnt_r[IDX_W-1:0]] <= in_data;
        end
        if (cap_s) begin
            obuf_r[oc_r[IDX_W-1:0]] <= bwt_char_out;
        end
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            in_cnt_r       <= '0;
            ld_cnt_r       <= '0;
            oc_r           <= '0;
            rd_r           <= '0;
            wc_r           <= '0;
            in_ready_r     <= 1'b0;
            out_valid_r    <= 1'b0;
            out_data_r     <= 8'h00;
            out_last_r     <= 1'b0;
            bwt_start_r    <= 1'b0;
            bwt_char_r     <= 8'h00;
            busy_r         <= 1'b0;
            err_timeout_r  <= 1'b0;
            err_spurious_r <= 1'b0;
            blocks_done_r  <= 16'h0000;
        end else begin
            state_r     <= state_nx;
            in_cnt_r    <= in_cnt_nx;
            ld_cnt_r    <= ld_cnt_nx;
            oc_r        <= oc_nx;
            rd_r        <= rd_nx;
            wc_r        <= wc_nx;
            in_ready_r  <= (in_cnt_nx < LEN_C) && (state_nx != ST_LOAD);
            busy_r      <= (state_nx != ST_IDLE);
            bwt_start_r <= (state_nx == ST_LOAD);
            bwt_char_r  <= (state_nx == ST_LOAD) ? ibuf_r[ld_cnt_nx[IDX_W-1:0]] : 8'h00;
            out_valid_r <= (state_nx == ST_DRAIN);
            out_data_r  <= (state_nx == ST_DRAIN) ? obuf_r[rd_nx[IDX_W-1:0]] : 8'h00;
            out_last_r  <= (state_nx == ST_DRAIN) && (rd_nx == LAST_C);
            // Error events beat a simultaneous clear.
            err_timeout_r  <= to_s   ? 1'b1 : (clr_err ? 1'b0 : err_timeout_r);
            err_spurious_r <= spur_s ? 1'b1 : (clr_err ? 1'b0 : err_spurious_r);
            blocks_done_r  <= done_s ? (blocks_done_r + 16'd1) : blocks_done_r;
        end
    end

endmodule
